// File: rtl/decoder_line_monitor_pkg.sv
// Shared definitions for the decoder line monitor: FSM encodings, line geometry
// and the helpers that classify and encode a sampled line vector.
package decoder_pkg;

    localparam int NUM_LINES     = 4;
    localparam int IDX_W         = 2;
    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_ONEHOT,
        CLS_MULTI
    } line_class_t;

    // A vector with exactly one bit set clears to zero when ANDed with itself minus one.
    function automatic line_class_t classify(input logic [NUM_LINES-1:0] v);
        if (v == '0) begin
            return CLS_ZERO;
        end
        if ((v & (v - NUM_LINES'(1))) == '0) begin
            return CLS_ONEHOT;
        end
        return CLS_MULTI;
    endfunction

    function automatic logic [IDX_W-1:0] encode(input logic [NUM_LINES-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < NUM_LINES; k++) begin
            if (v[k]) begin
                idx = IDX_W'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/decoder_line_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         CLR,
    input  logic         INC,
    output logic [W-1:0] Q
);

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Q <= '0;
        end else if (CLR) begin
            Q <= '0;
        end else if (INC && (Q != '1)) begin
            Q <= Q + W'(1);
        end
    end

endmodule

// File: rtl/decoder_line_monitor.sv
// Registers the decoder's one-hot lines, re-encodes the active line, counts
// per-line rising edges and flags multi-hot samples.
module decoder_line_monitor
    import decoder_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             m1,
    input  logic             m2,
    input  logic             m3,
    input  logic             m4,
    input  logic             CLR,
    input  logic [IDX_W-1:0] SEL,
    output logic             VALID,
    output logic [IDX_W-1:0] IDX,
    output logic [CNT_W-1:0] COUNT,
    output logic             ERR,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [1:0]       STATE
);

    logic [NUM_LINES-1:0] s;
    logic [NUM_LINES-1:0] s_prev;
    line_class_t          s_class;
    logic [NUM_LINES-1:0] line_inc;
    logic                 err_inc;
    logic [CNT_W-1:0]     cnt [NUM_LINES];
    state_t               state;
    state_t               state_nxt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s      <= '0;
            s_prev <= '0;
        end else begin
            s      <= {m4, m3, m2, m1};
            s_prev <= s;
        end
    end

    assign s_class = classify(s);
    // Edges that arrive inside a multi-hot sample are deliberately not counted.
    assign line_inc = (s_class == CLS_ONEHOT) ? (s & ~s_prev) : '0;
    assign err_inc  = (s_class == CLS_MULTI);

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_line_cnt
        sat_counter #(.W(CNT_W)) u_line_cnt (
            .CLK   (CLK),
            .RST_N (RST_N),
            .CLR   (CLR),
            .INC   (line_inc[g]),
            .Q     (cnt[g])
        );
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CLR   (CLR),
        .INC   (err_inc),
        .Q     (ERR_CNT)
    );

    // COUNT samples the selected counter before this edge's increment lands.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            VALID <= 1'b0;
            IDX   <= '0;
            COUNT <= '0;
            ERR   <= 1'b0;
        end else begin
            VALID <= (s_class == CLS_ONEHOT);
            if (s_class == CLS_ONEHOT) begin
                IDX <= encode(s);
            end
            COUNT <= cnt[SEL];
            if (CLR) begin
                ERR <= 1'b0;
            end else if (err_inc) begin
                ERR <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (s_class == CLS_ONEHOT)      state_nxt = ST_ACTIVE;
                else if (s_class == CLS_MULTI)  state_nxt = ST_FAULT;
            end
            ST_ACTIVE: begin
                if (s_class == CLS_ZERO)        state_nxt = ST_IDLE;
                else if (s_class == CLS_MULTI)  state_nxt = ST_FAULT;
            end
            ST_FAULT: begin
                if (s_class == CLS_ZERO)        state_nxt = ST_IDLE;
                else if (s_class == CLS_ONEHOT) state_nxt = ST_ACTIVE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        STATE = state;
    end

endmodule

// File: tb/tb_decoder_line_monitor.sv
// Bench for decoder_line_monitor: two widths driven in parallel, checked each
// cycle against a behavioural model, plus hand-computed directed expectations.
module tb_decoder_line_monitor;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [3:0] m_in;
    logic       clr;
    logic [1:0] sel;

    logic       valid8, valid3, err8, err3;
    logic [1:0] idx8, idx3, state8, state3;
    logic [7:0] count8, err_cnt8;
    logic [2:0] count3, err_cnt3;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    logic [3:0] ms  = 4'b0000;
    logic [3:0] msp = 4'b0000;
    int cnt8 [4];
    int cnt3 [4];
    int e_ec8 = 0, e_ec3 = 0, e_cnt_rd8 = 0, e_cnt_rd3 = 0;
    int e_valid = 0, e_idx = 0, e_err = 0, e_state = 0;

    always #5 CLK = ~CLK;

    decoder_line_monitor #(.CNT_W(8)) u_dut8 (
        .CLK(CLK), .RST_N(RST_N),
        .m1(m_in[0]), .m2(m_in[1]), .m3(m_in[2]), .m4(m_in[3]),
        .CLR(clr), .SEL(sel),
        .VALID(valid8), .IDX(idx8), .COUNT(count8),
        .ERR(err8), .ERR_CNT(err_cnt8), .STATE(state8)
    );

    decoder_line_monitor #(.CNT_W(3)) u_dut3 (
        .CLK(CLK), .RST_N(RST_N),
        .m1(m_in[0]), .m2(m_in[1]), .m3(m_in[2]), .m4(m_in[3]),
        .CLR(clr), .SEL(sel),
        .VALID(valid3), .IDX(idx3), .COUNT(count3),
        .ERR(err3), .ERR_CNT(err_cnt3), .STATE(state3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int sat_inc(input int v, input int mx);
        return (v < mx) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        ms = 4'b0000; msp = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            cnt8[k] = 0; cnt3[k] = 0;
        end
        e_ec8 = 0; e_ec3 = 0; e_cnt_rd8 = 0; e_cnt_rd3 = 0;
        e_valid = 0; e_idx = 0; e_err = 0; e_state = 0;
    endtask

    // Model: what each edge must produce, from the population count of the sample.
    initial begin : model
        int pc;
        model_reset();
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) begin
                model_reset();
            end else begin
                pc = $countones(ms);
                e_cnt_rd8 = cnt8[sel];
                e_cnt_rd3 = cnt3[sel];
                for (int k = 0; k < 4; k++) begin
                    if (pc == 1 && ms[k] && !msp[k]) begin
                        cnt8[k] = sat_inc(cnt8[k], 255);
                        cnt3[k] = sat_inc(cnt3[k], 7);
                    end
                end
                if (pc >= 2) begin
                    e_ec8 = sat_inc(e_ec8, 255);
                    e_ec3 = sat_inc(e_ec3, 7);
                    e_err = 1;
                end
                if (clr) begin
                    for (int k = 0; k < 4; k++) begin
                        cnt8[k] = 0; cnt3[k] = 0;
                    end
                    e_ec8 = 0; e_ec3 = 0; e_err = 0;
                end
                e_valid = (pc == 1) ? 1 : 0;
                if (pc == 1) begin
                    for (int k = 0; k < 4; k++) if (ms[k]) e_idx = k;
                end
                e_state = (pc == 0) ? 0 : ((pc == 1) ? 1 : 2);
                msp = ms;
                ms  = m_in;
            end
        end
    end

    // Compare every cycle, half a period away from the active edge.
    initial begin : compare
        forever begin
            @(negedge CLK);
            check("valid8",   32'(valid8),   32'(e_valid));
            check("idx8",     32'(idx8),     32'(e_idx));
            check("count8",   32'(count8),   32'(e_cnt_rd8));
            check("err8",     32'(err8),     32'(e_err));
            check("err_cnt8", 32'(err_cnt8), 32'(e_ec8));
            check("state8",   32'(state8),   32'(e_state));
            check("valid3",   32'(valid3),   32'(e_valid));
            check("idx3",     32'(idx3),     32'(e_idx));
            check("count3",   32'(count3),   32'(e_cnt_rd3));
            check("err3",     32'(err3),     32'(e_err));
            check("err_cnt3", 32'(err_cnt3), 32'(e_ec3));
            check("state3",   32'(state3),   32'(e_state));
        end
    end

    task automatic tick(input logic [3:0] m, input logic c, input logic [1:0] s);
        @(negedge CLK);
        m_in = m; clr = c; sel = s;
        @(posedge CLK);
        #1;
    endtask

    initial begin : stim
        logic [3:0] rm;
        int r;
        m_in = 4'b0100; clr = 1'b0; sel = 2'd2; RST_N = 1'b1;
        #1 RST_N = 1'b0;

        // Reset with m3 high: everything at zero, then release.
        repeat (2) @(negedge CLK);
        check("rst_valid", 32'(valid8), 0);
        check("rst_state", 32'(state8), 0);
        check("rst_count", 32'(count8), 0);
        check("rst_errcnt", 32'(err_cnt8), 0);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        check("rel1_valid", 32'(valid8), 0);
        @(posedge CLK); #1;
        check("rel2_valid", 32'(valid8), 1);
        check("rel2_idx", 32'(idx8), 2);
        check("rel2_state", 32'(state8), 1);
        @(posedge CLK); #1;
        check("rel3_cnt2", 32'(count8), 1);

        // Sweep m1..m4 three times, then read all four counters.
        tick(4'b0000, 1'b1, 2'd0);
        for (int rep = 0; rep < 3; rep++) begin
            for (int k = 0; k < 4; k++) tick(4'(1 << k), 1'b0, 2'd0);
        end
        for (int k = 0; k < 4; k++) begin
            tick(4'b1000, 1'b0, 2'(k));
            check("sweep_cnt8", 32'(count8), 3);
            check("sweep_cnt3", 32'(count3), 3);
        end
        check("sweep_err", 32'(err8), 0);
        check("sweep_state", 32'(state8), 1);

        // Hold m3 for ten cycles: a single edge.
        for (int i = 0; i < 10; i++) begin
            tick(4'b0100, 1'b0, 2'd2);
            if (i >= 1) begin
                check("hold_valid", 32'(valid8), 1);
                check("hold_idx", 32'(idx8), 2);
            end
        end
        tick(4'b0100, 1'b0, 2'd2);
        check("hold_cnt2", 32'(count8), 4);

        // Two multi-hot samples, then back to zero.
        tick(4'b0110, 1'b0, 2'd2);
        tick(4'b0110, 1'b0, 2'd2);
        tick(4'b0000, 1'b0, 2'd1);
        check("multi_errcnt", 32'(err_cnt8), 2);
        check("multi_err", 32'(err8), 1);
        check("multi_state", 32'(state8), 2);
        check("multi_idx", 32'(idx8), 2);
        check("multi_cnt1", 32'(count8), 3);
        tick(4'b0000, 1'b0, 2'd1);
        check("idle_state", 32'(state8), 0);
        check("idle_err", 32'(err8), 1);

        // Toggle m1 ten times: narrow counter saturates at 7.
        for (int i = 0; i < 10; i++) begin
            tick(4'b0001, 1'b0, 2'd0);
            tick(4'b0000, 1'b0, 2'd0);
        end
        tick(4'b0000, 1'b0, 2'd0);
        check("sat_cnt3", 32'(count3), 7);
        check("sat_cnt8", 32'(count8), 13);

        // CLR coincides with the m2 edge being evaluated: edge lost.
        tick(4'b0010, 1'b0, 2'd1);
        tick(4'b0010, 1'b1, 2'd1);
        tick(4'b0010, 1'b0, 2'd1);
        check("clr_cnt1", 32'(count8), 0);
        check("clr_err", 32'(err8), 0);
        check("clr_errcnt", 32'(err_cnt8), 0);
        check("clr_valid", 32'(valid8), 1);
        check("clr_state", 32'(state8), 1);

        // Asynchronous reset mid-sweep.
        tick(4'b0001, 1'b0, 2'd0);
        tick(4'b0010, 1'b0, 2'd0);
        tick(4'b0100, 1'b0, 2'd0);
        #2 RST_N = 1'b0;
        #1;
        check("async_valid", 32'(valid8), 0);
        check("async_state", 32'(state8), 0);
        check("async_count", 32'(count8), 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;

        // Randomised traffic with rare clears and resets.
        rm = 4'b0000;
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 45)      rm = 4'(1 << $urandom_range(0, 3));
            else if (r < 65) rm = 4'b0000;
            else if (r < 85) rm = rm;
            else             rm = 4'($urandom_range(0, 15));
            tick(rm, ($urandom_range(0, 49) == 0), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 199) == 0) begin
                #2 RST_N = 1'b0;
                @(negedge CLK);
                RST_N = 1'b1;
            end
        end

        @(negedge CLK);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
